gelato_operand_collector: RTL and testbench

- Operand-collection stage between the warp issue stage and the ALU/dispatch stage.
- Holds up to COLLECTOR_NUM in-flight instructions as collector_entry_t.
- Issues register-file reads for rs1/rs2/rs3 and gathers the tagged warp-wide read data.
- Dispatches an instruction with all three operands (inst_t plus three warp_reg_t) once every operand is valid.

---
 rtl/gelato_operand_collector_pkg.sv | 52 +++++
 rtl/gelato_operand_collector_rr_arbiter.sv | 39 +++
 rtl/gelato_operand_collector.sv | 122 ++++++++++++
 tb/tb_gelato_operand_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_operand_collector_pkg.sv
// gelato_operand_collector_pkg: shared types for the operand collector.
// Entry records, register-file request/response tags and sizing constants.
package gelato_operand_collector_pkg;
    localparam int COLLECTOR_NUM = 4;
    localparam int THREAD_NUM    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int COLLECTOR_W   = $clog2(COLLECTOR_NUM);
    localparam int WARP_W        = 5;
    localparam int REG_W         = 5;
    localparam int WREG_W        = THREAD_NUM * DATA_WIDTH;

    typedef logic [WARP_W-1:0]      warp_num_t;
    typedef logic [REG_W-1:0]       reg_num_t;
    typedef logic [COLLECTOR_W-1:0] collector_num_t;
    typedef logic [1:0]             rs_num_t;
    typedef logic [WREG_W-1:0]      warp_reg_t;

    typedef struct packed {
        logic [7:0] op;
        warp_num_t  warp;
        reg_num_t   rd;
        reg_num_t   rs1;
        reg_num_t   rs2;
        reg_num_t   rs3;
    } inst_t;

    // Slot k of rs_valid/req_sent/rs_data belongs to operand rs(k+1).
    typedef struct packed {
        logic            valid;
        inst_t           inst;
        logic [2:0]      rs_valid;
        logic [2:0]      req_sent;
        warp_reg_t [2:0] rs_data;
    } collector_entry_t;

    typedef struct packed {
        warp_num_t      warp;
        reg_num_t       reg_idx;
        collector_num_t collector;
        rs_num_t        rs;
    } collector_req_t;

    typedef struct packed {
        collector_num_t collector;
        rs_num_t        rs;
        warp_reg_t      data;
    } collector_rsp_t;

    function automatic reg_num_t rs_reg(inst_t i, rs_num_t r);
        return r == 2'd1 ? i.rs1 : r == 2'd2 ? i.rs2 : i.rs3;
    endfunction
endpackage

// File: rtl/gelato_operand_collector_rr_arbiter.sv
// gelato_rr_arbiter: round-robin pick starting at the slot after the last accept.
// An unaccepted grant is frozen so the consumer sees stable outputs.
module gelato_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] grant_o
);
    logic [W-1:0] ptr_q, held_q, pick;
    logic         lock_q;

    always_comb begin
        pick = ptr_q;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[ptr_q + W'(i)]) pick = ptr_q + W'(i);
    end

    assign valid_o = |req_i;
    assign idx_o   = lock_q ? held_q : pick;
    assign grant_o = valid_o ? N'(1) << idx_o : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            held_q <= '0;
            lock_q <= 1'b0;
        end else begin
            lock_q <= valid_o && !accept_i;
            held_q <= idx_o;
            if (valid_o && accept_i) ptr_q <= idx_o + W'(1);
        end
    end
endmodule

// File: rtl/gelato_operand_collector.sv
// gelato_operand_collector: gathers rs1/rs2/rs3 warp registers per instruction
// and dispatches instructions once every operand has arrived.
module gelato_operand_collector
    import gelato_operand_collector_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           issue_valid,
    output logic           issue_ready,
    input  inst_t          issue_inst,
    output logic           rf_req_valid,
    input  logic           rf_req_ready,
    output warp_num_t      rf_req_warp,
    output reg_num_t       rf_req_reg,
    output collector_num_t rf_req_collector,
    output rs_num_t        rf_req_rs,
    input  logic           rf_rsp_valid,
    input  collector_num_t rf_rsp_collector,
    input  rs_num_t        rf_rsp_rs,
    input  warp_reg_t      rf_rsp_data,
    output logic           disp_valid,
    input  logic           disp_ready,
    output inst_t          disp_inst,
    output warp_reg_t      disp_rs1,
    output warp_reg_t      disp_rs2,
    output warp_reg_t      disp_rs3
);
    collector_entry_t           ent_q [COLLECTOR_NUM];
    collector_entry_t           ent_d [COLLECTOR_NUM];
    logic [2:0]                 slot_cand [COLLECTOR_NUM];
    logic [COLLECTOR_NUM-1:0]   free_v, req_cand, comp, req_grant, disp_grant;
    collector_num_t             alloc_idx, req_idx, disp_idx;
    logic [2:0]                 sel, slot_oh;
    rs_num_t                    req_rs;
    logic                       alloc;
    collector_req_t             req;
    collector_rsp_t             rsp;

    always_comb begin
        alloc_idx = '0;
        for (int c = COLLECTOR_NUM - 1; c >= 0; c--) begin
            free_v[c]    = !ent_q[c].valid;
            slot_cand[c] = ent_q[c].valid ? ~ent_q[c].rs_valid & ~ent_q[c].req_sent : 3'b0;
            req_cand[c]  = |slot_cand[c];
            comp[c]      = ent_q[c].valid && &ent_q[c].rs_valid;
            if (!ent_q[c].valid) alloc_idx = collector_num_t'(c);
        end
    end

    assign issue_ready = |free_v;
    assign alloc       = issue_valid && issue_ready;

    gelato_rr_arbiter #(.N(COLLECTOR_NUM)) u_req_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_cand),
        .accept_i (rf_req_ready),
        .valid_o  (rf_req_valid),
        .idx_o    (req_idx),
        .grant_o  (req_grant)
    );

    gelato_rr_arbiter #(.N(COLLECTOR_NUM)) u_disp_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (comp),
        .accept_i (disp_ready),
        .valid_o  (disp_valid),
        .idx_o    (disp_idx),
        .grant_o  (disp_grant)
    );

    // Lowest pending slot of the granted collector gives rs1 > rs2 > rs3 priority.
    assign sel     = slot_cand[req_idx];
    assign slot_oh = sel & (~sel + 3'd1);
    assign req_rs  = sel[0] ? 2'd1 : sel[1] ? 2'd2 : 2'd3;
    assign req     = rf_req_valid ? collector_req_t'{
                         warp:      ent_q[req_idx].inst.warp,
                         reg_idx:   rs_reg(ent_q[req_idx].inst, req_rs),
                         collector: req_idx,
                         rs:        req_rs} : '0;

    assign rf_req_warp      = req.warp;
    assign rf_req_reg       = req.reg_idx;
    assign rf_req_collector = req.collector;
    assign rf_req_rs        = req.rs;

    assign rsp = '{collector: rf_rsp_collector, rs: rf_rsp_rs, data: rf_rsp_data};

    assign disp_inst = disp_valid ? ent_q[disp_idx].inst : '0;
    assign disp_rs1  = disp_valid ? ent_q[disp_idx].rs_data[0] : '0;
    assign disp_rs2  = disp_valid ? ent_q[disp_idx].rs_data[1] : '0;
    assign disp_rs3  = disp_valid ? ent_q[disp_idx].rs_data[2] : '0;

    always_comb begin
        ent_d = ent_q;
        for (int c = 0; c < COLLECTOR_NUM; c++) begin
            if (disp_grant[c] && disp_ready) begin
                ent_d[c].valid    = 1'b0;
                ent_d[c].rs_valid = '0;
                ent_d[c].req_sent = '0;
            end
            if (alloc && alloc_idx == collector_num_t'(c)) begin
                ent_d[c].valid    = 1'b1;
                ent_d[c].inst     = issue_inst;
                ent_d[c].rs_valid = {issue_inst.rs3 == '0, issue_inst.rs2 == '0, issue_inst.rs1 == '0};
                ent_d[c].req_sent = '0;
                ent_d[c].rs_data  = '0;
            end
            if (req_grant[c] && rf_req_ready) ent_d[c].req_sent = ent_q[c].req_sent | slot_oh;
            if (rf_rsp_valid && rsp.collector == collector_num_t'(c) && rsp.rs != 2'd0 && ent_q[c].valid) begin
                ent_d[c].rs_valid[rsp.rs - 2'd1] = 1'b1;
                ent_d[c].rs_data[rsp.rs - 2'd1]  = rsp.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ent_q <= '{default: '0};
        else        ent_q <= ent_d;
    end
endmodule

// File: tb/tb_gelato_operand_collector.sv
// tb_gelato_operand_collector: directed vectors plus multi-cycle corner sequences.
module tb_gelato_operand_collector;
    import gelato_operand_collector_pkg::*;
    localparam int W = WREG_W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           issue_valid, issue_ready;
    inst_t          issue_inst;
    logic           rf_req_valid, rf_req_ready;
    warp_num_t      rf_req_warp;
    reg_num_t       rf_req_reg;
    collector_num_t rf_req_collector;
    rs_num_t        rf_req_rs;
    logic           rf_rsp_valid;
    collector_num_t rf_rsp_collector;
    rs_num_t        rf_rsp_rs;
    warp_reg_t      rf_rsp_data;
    logic           disp_valid, disp_ready;
    inst_t          disp_inst;
    warp_reg_t      disp_rs1, disp_rs2, disp_rs3;

    gelato_operand_collector dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
        .rf_req_valid(rf_req_valid), .rf_req_ready(rf_req_ready), .rf_req_warp(rf_req_warp),
        .rf_req_reg(rf_req_reg), .rf_req_collector(rf_req_collector), .rf_req_rs(rf_req_rs),
        .rf_rsp_valid(rf_rsp_valid), .rf_rsp_collector(rf_rsp_collector), .rf_rsp_rs(rf_rsp_rs),
        .rf_rsp_data(rf_rsp_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rs3(disp_rs3)
    );

    always #5 clk = ~clk;

    typedef struct { collector_num_t col; rs_num_t rs; reg_num_t rg; warp_num_t warp; int cyc; } req_rec_t;
    typedef struct { inst_t inst; warp_reg_t r1, r2, r3; int cyc; } disp_rec_t;
    typedef struct { warp_num_t warp; reg_num_t rs1, rs2, rs3; int nreq; int lat; } vec_t;

    req_rec_t       reqlog[$];
    disp_rec_t      displog[$];
    int             cyc, n_vec, n_bad, issue_cyc;
    logic           issue_hs, auto_rf, pend_v;
    collector_num_t pend_col;
    rs_num_t        pend_rs;
    warp_reg_t      pend_data;

    function automatic warp_reg_t rf_val(warp_num_t w, reg_num_t r);
        warp_reg_t v;
        for (int t = 0; t < THREAD_NUM; t++)
            v[t*32 +: 32] = {8'hA5, 3'b0, w, 3'b0, r, 8'(t)};
        return v;
    endfunction

    function automatic warp_reg_t op_exp(warp_num_t w, reg_num_t r);
        return r == '0 ? '0 : rf_val(w, r);
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        int lane;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            lane = 0;
            for (int l = THREAD_NUM - 1; l >= 0; l--)
                if (act[l*32 +: 32] !== exp[l*32 +: 32]) lane = l;
            $display("FAIL %s: lane %0d got %h expected %h", nm, lane, act[lane*32 +: 32], exp[lane*32 +: 32]);
        end
    endtask

    // Observe handshakes mid-cycle, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        issue_hs = issue_valid && issue_ready;
        if (issue_hs) issue_cyc = cyc;
        if (rf_req_valid && rf_req_ready) begin
            reqlog.push_back(req_rec_t'{rf_req_collector, rf_req_rs, rf_req_reg, rf_req_warp, cyc});
            if (auto_rf) begin
                pend_v    = 1'b1;
                pend_col  = rf_req_collector;
                pend_rs   = rf_req_rs;
                pend_data = rf_val(rf_req_warp, rf_req_reg);
            end
        end
        if (disp_valid && disp_ready)
            displog.push_back(disp_rec_t'{disp_inst, disp_rs1, disp_rs2, disp_rs3, cyc});
        @(posedge clk);
        #1;
        cyc++;
        rf_rsp_valid     = auto_rf && pend_v;
        rf_rsp_collector = pend_col;
        rf_rsp_rs        = pend_rs;
        rf_rsp_data      = pend_data;
        pend_v           = 1'b0;
    endtask

    task automatic do_issue(inst_t i);
        issue_inst  = i;
        issue_valid = 1'b1;
        tick();
        chk("issue_hs", W'(issue_hs), W'(1));
        issue_valid = 1'b0;
    endtask

    task automatic wait_disp(int n, int budget);
        for (int k = 0; k < budget && displog.size() < n; k++) tick();
        chk("disp_count", W'(displog.size()), W'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t     vt[5];
        reg_num_t er[3];
        int       ne;
        inst_t    ins, ia, ib;

        vt[0] = '{5'd3, 5'd0,  5'd0,  5'd0,  0, 1};
        vt[1] = '{5'd1, 5'd5,  5'd6,  5'd0,  2, 4};
        vt[2] = '{5'd2, 5'd0,  5'd7,  5'd0,  1, 3};
        vt[3] = '{5'd4, 5'd9,  5'd10, 5'd11, 3, 5};
        vt[4] = '{5'd7, 5'd0,  5'd0,  5'd12, 1, 3};

        n_vec = 0; n_bad = 0; cyc = 0; issue_cyc = 0;
        auto_rf = 1'b1; pend_v = 1'b0; pend_col = '0; pend_rs = '0; pend_data = '0;
        rst_n = 1'b0; issue_valid = 1'b0; issue_inst = '0; rf_req_ready = 1'b1;
        rf_rsp_valid = 1'b0; rf_rsp_collector = '0; rf_rsp_rs = '0; rf_rsp_data = '0;
        disp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ready", W'(issue_ready), W'(1));
        chk("rst_req_valid", W'(rf_req_valid), W'(0));
        chk("rst_disp_valid", W'(disp_valid), W'(0));
        chk("rst_disp_rs1", disp_rs1, '0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            reqlog.delete();
            displog.delete();
            ins = '{op: 8'(8'h10 + k), warp: vt[k].warp, rd: 5'd1, rs1: vt[k].rs1, rs2: vt[k].rs2, rs3: vt[k].rs3};
            ne = 0;
            if (vt[k].rs1 != '0) begin er[ne] = vt[k].rs1; ne++; end
            if (vt[k].rs2 != '0) begin er[ne] = vt[k].rs2; ne++; end
            if (vt[k].rs3 != '0) begin er[ne] = vt[k].rs3; ne++; end
            do_issue(ins);
            wait_disp(1, 30);
            chk("vec_nreq", W'(reqlog.size()), W'(vt[k].nreq));
            for (int j = 0; j < ne && j < reqlog.size(); j++) begin
                chk("vec_req_reg", W'(reqlog[j].rg), W'(er[j]));
                chk("vec_req_warp", W'(reqlog[j].warp), W'(vt[k].warp));
            end
            if (displog.size() > 0) begin
                chk("vec_latency", W'(displog[0].cyc - issue_cyc), W'(vt[k].lat));
                chk("vec_inst", W'(displog[0].inst), W'(ins));
                chk("vec_rs1", displog[0].r1, op_exp(vt[k].warp, vt[k].rs1));
                chk("vec_rs2", displog[0].r2, op_exp(vt[k].warp, vt[k].rs2));
                chk("vec_rs3", displog[0].r3, op_exp(vt[k].warp, vt[k].rs3));
            end
            tick();
            chk("vec_idle_disp", W'(disp_valid), W'(0));
        end

        // Fill every collector while the register file stalls.
        auto_rf = 1'b0;
        rf_req_ready = 1'b0;
        reqlog.delete();
        displog.delete();
        for (int i = 0; i < 4; i++)
            do_issue('{op: 8'(8'h40 + i), warp: 5'(i), rd: 5'd0, rs1: 5'(20 + i), rs2: 5'd0, rs3: 5'd0});
        issue_inst  = '{op: 8'h4F, warp: 5'd8, rd: 5'd0, rs1: 5'd30, rs2: 5'd0, rs3: 5'd0};
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_issue_ready", W'(issue_ready), W'(0));
            chk("full_issue_hs", W'(issue_hs), W'(0));
            chk("stall_req_valid", W'(rf_req_valid), W'(1));
            chk("stall_req_col", W'(rf_req_collector), W'(0));
            chk("stall_req_reg", W'(rf_req_reg), W'(20));
            chk("stall_req_rs", W'(rf_req_rs), W'(1));
        end
        issue_valid  = 1'b0;
        rf_req_ready = 1'b1;
        repeat (4) tick();
        chk("rr_req_count", W'(reqlog.size()), W'(4));
        for (int i = 0; i < 4 && i < reqlog.size(); i++) begin
            chk("rr_req_col", W'(reqlog[i].col), W'(i));
            chk("rr_req_reg", W'(reqlog[i].rg), W'(20 + i));
        end
        tick();
        chk("rr_req_idle", W'(rf_req_valid), W'(0));

        // Reverse-order responses dispatch in completion order without mixing data.
        for (int k = 3; k >= 0; k--) begin
            rf_rsp_valid     = 1'b1;
            rf_rsp_collector = collector_num_t'(k);
            rf_rsp_rs        = 2'd1;
            rf_rsp_data      = rf_val(5'(k), 5'(20 + k));
            tick();
        end
        wait_disp(4, 20);
        for (int j = 0; j < 4 && j < displog.size(); j++) begin
            chk("rev_disp_warp", W'(displog[j].inst.warp), W'(3 - j));
            chk("rev_disp_rs1", displog[j].r1, rf_val(5'(3 - j), 5'(23 - j)));
            chk("rev_disp_rs2", displog[j].r2, '0);
        end

        // Downstream stall with two complete entries.
        disp_ready = 1'b0;
        displog.delete();
        ia = '{op: 8'hA1, warp: 5'd9,  rd: 5'd3, rs1: 5'd0, rs2: 5'd0, rs3: 5'd0};
        ib = '{op: 8'hB2, warp: 5'd10, rd: 5'd4, rs1: 5'd0, rs2: 5'd0, rs3: 5'd0};
        do_issue(ia);
        do_issue(ib);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_disp_valid", W'(disp_valid), W'(1));
            chk("hold_disp_inst", W'(disp_inst), W'(ia));
        end
        disp_ready = 1'b1;
        wait_disp(2, 10);
        if (displog.size() == 2) begin
            chk("hold_first", W'(displog[0].inst), W'(ia));
            chk("hold_second", W'(displog[1].inst), W'(ib));
            chk("hold_back_to_back", W'(displog[1].cyc - displog[0].cyc), W'(1));
        end

        // Reset with three requests outstanding.
        reqlog.delete();
        displog.delete();
        do_issue('{op: 8'hC3, warp: 5'd6, rd: 5'd2, rs1: 5'd13, rs2: 5'd14, rs3: 5'd15});
        repeat (3) tick();
        chk("mid_req_count", W'(reqlog.size()), W'(3));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_issue_ready", W'(issue_ready), W'(1));
        chk("mid_rst_disp_valid", W'(disp_valid), W'(0));
        chk("mid_rst_req_valid", W'(rf_req_valid), W'(0));
        tick();
        rst_n = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            rf_rsp_valid     = 1'b1;
            rf_rsp_collector = '0;
            rf_rsp_rs        = rs_num_t'(r);
            rf_rsp_data      = rf_val(5'd6, 5'(12 + r));
            tick();
        end
        tick();
        chk("late_rsp_disp", W'(disp_valid), W'(0));
        chk("late_rsp_req", W'(rf_req_valid), W'(0));
        chk("late_rsp_ready", W'(issue_ready), W'(1));
        auto_rf = 1'b1;
        reqlog.delete();
        displog.delete();
        do_issue('{op: 8'hD4, warp: 5'd5, rd: 5'd1, rs1: 5'd13, rs2: 5'd0, rs3: 5'd0});
        wait_disp(1, 20);
        if (displog.size() > 0) begin
            chk("post_rst_latency", W'(displog[0].cyc - issue_cyc), W'(3));
            chk("post_rst_rs1", displog[0].r1, rf_val(5'd5, 5'd13));
            chk("post_rst_rs2", displog[0].r2, '0);
            chk("post_rst_rs3", displog[0].r3, '0);
        end
        chk("post_rst_req_count", W'(reqlog.size()), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
